// File: rtl/cdb_broadcaster.sv
// Common data bus transmit end: per-unit 2-entry result queues, round-robin grant
// of up to four queued results per cycle onto four registered CDB lanes.
module cdb_broadcaster #(
  parameter int NUM_FU     = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        fu_valid_i     [0:NUM_FU-1],
  input  logic [3:0]  fu_rob_index_i [0:NUM_FU-1],
  input  logic [15:0] fu_result_i    [0:NUM_FU-1],
  output logic        fu_ready_o     [0:NUM_FU-1],
  output logic        cdb_valid_o     [0:3],
  output logic [3:0]  cdb_rob_index_o [0:3],
  output logic [15:0] cdb_result_o    [0:3],
  output logic        overflow_o
);

  localparam int               LANES    = 4;
  localparam int               RR_W     = $clog2(NUM_FU);
  localparam logic [RR_W:0]    NUM_FU_W = (RR_W+1)'(NUM_FU);
  localparam logic [RR_W-1:0]  LAST_FU  = RR_W'(NUM_FU - 1);
  localparam logic [1:0]       FULL_CNT = 2'(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0]  rob_index;
    logic [15:0] result;
  } entry_t;

  // Entry 0 is always the queue head; a pop shifts entry 1 down.
  entry_t          ent_q [NUM_FU][FIFO_DEPTH];
  entry_t          ent_d [NUM_FU][FIFO_DEPTH];
  logic [1:0]      cnt_q [NUM_FU];
  logic [1:0]      cnt_d [NUM_FU];
  logic [RR_W-1:0] rr_q, rr_d;
  logic            overflow_q, ovf_set;

  logic            grant      [NUM_FU];
  logic            lane_vld_d [LANES];
  entry_t          lane_d     [LANES];
  logic            cdb_vld_q  [LANES];
  entry_t          cdb_q      [LANES];

  logic [2:0]      n_grant;
  logic [RR_W:0]   scan;
  logic [RR_W-1:0] unit;
  logic            push;
  logic [1:0]      base;

  // Round-robin scan from rr; the k-th non-empty queue found feeds lane k.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so the loop sees its own running updates and no latch is inferred.
    n_grant = '0;
    rr_d    = rr_q;
    scan    = '0;
    unit    = '0;
    for (int f = 0; f < NUM_FU; f++) grant[f] = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_vld_d[k] = 1'b0;
      lane_d[k]     = '0;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      scan = {1'b0, rr_q} + (RR_W+1)'(i);
      if (scan >= NUM_FU_W) scan = scan - NUM_FU_W;
      unit = scan[RR_W-1:0];
      if (cnt_q[unit] != 2'd0 && n_grant < 3'd4) begin
        grant[unit]              = 1'b1;
        lane_vld_d[n_grant[1:0]] = 1'b1;
        lane_d[n_grant[1:0]]     = ent_q[unit][0];
        n_grant                  = n_grant + 3'd1;
        rr_d                     = (unit == LAST_FU) ? '0 : unit + RR_W'(1);
      end
    end
  end

  // Queue next state: pop first, then push lands at the post-pop tail.
  always_comb begin
    ovf_set = 1'b0;
    push    = 1'b0;
    base    = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      push        = fu_valid_i[f] && (cnt_q[f] != FULL_CNT);
      ovf_set     = ovf_set | (fu_valid_i[f] && (cnt_q[f] == FULL_CNT));
      ent_d[f][0] = grant[f] ? ent_q[f][1] : ent_q[f][0];
      ent_d[f][1] = ent_q[f][1];
      base        = cnt_q[f] - {1'b0, grant[f]};
      if (push) begin
        if (base == 2'd0) ent_d[f][0] = {fu_rob_index_i[f], fu_result_i[f]};
        else              ent_d[f][1] = {fu_rob_index_i[f], fu_result_i[f]};
      end
      cnt_d[f] = cnt_q[f] + {1'b0, push} - {1'b0, grant[f]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
      for (int f = 0; f < NUM_FU; f++) cnt_q[f] <= '0;
      for (int k = 0; k < LANES; k++) begin
        cdb_vld_q[k] <= 1'b0;
        cdb_q[k]     <= '0;
      end
    end else if (flush_i) begin
      for (int f = 0; f < NUM_FU; f++) cnt_q[f] <= '0;
      for (int k = 0; k < LANES; k++) begin
        cdb_vld_q[k] <= 1'b0;
        cdb_q[k]     <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      overflow_q <= overflow_q | ovf_set;
      for (int f = 0; f < NUM_FU; f++) cnt_q[f] <= cnt_d[f];
      for (int k = 0; k < LANES; k++) begin
        cdb_vld_q[k] <= lane_vld_d[k];
        cdb_q[k]     <= lane_d[k];
      end
    end
  end

  // NOTE: queue storage has no reset; entries are only observed while cnt_q marks them valid.
  always_ff @(posedge clk) begin
    for (int f = 0; f < NUM_FU; f++)
      for (int d = 0; d < FIFO_DEPTH; d++) ent_q[f][d] <= ent_d[f][d];
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) fu_ready_o[f] = (cnt_q[f] != FULL_CNT);
    for (int k = 0; k < LANES; k++) begin
      cdb_valid_o[k]     = cdb_vld_q[k];
      cdb_rob_index_o[k] = cdb_q[k].rob_index;
      cdb_result_o[k]    = cdb_q[k].result;
    end
    overflow_o = overflow_q;
  end

endmodule
